// File: rtl/fixed_point_square_iterative_pkg.sv
// Shared definitions for the fixed-point squarer (and its square-root sibling).
// Holds the default operand/result widths, the fraction-bit count and the
// control state encoding so both units can reuse the same sequencer states.
package fixed_point_square_iterative_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned LONG_WIDTH = 64;
    localparam int unsigned SCALE      = 17;

    // Encoding is fixed so the sqrt/square control paths stay interchangeable.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/square_shift_add_step.sv
// One radix-2 shift-add multiplication step (combinational).
// Ports:
//   i_acc        - running partial product, 2*Width bits
//   i_mcand      - multiplicand magnitude, Width bits
//   i_mplier_bit - current multiplier bit (LSB of the shifting multiplier)
//   i_count      - bit position of this step
//   o_acc        - partial product after this step
// Kept as its own block so a multi-bit (radix-4) step can replace it later.
module square_shift_add_step #(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = $clog2(Width)
) (
    input  logic [2*Width-1:0] i_acc,
    input  logic [Width-1:0]   i_mcand,
    input  logic               i_mplier_bit,
    input  logic [CntW-1:0]    i_count,
    output logic [2*Width-1:0] o_acc
);

    logic [2*Width-1:0] w_addend;

    // Zero-extend before shifting so the top partial products are not lost.
    assign w_addend = {{Width{1'b0}}, i_mcand} << i_count;
    assign o_acc    = i_mplier_bit ? (i_acc + w_addend) : i_acc;

endmodule

// File: rtl/fixed_point_square_iterative.sv
// Sequential fixed-point squarer: Result = (Operand*Operand) >> Scale,
// one shift-add step per clock, fixed Width iterations.
// Ports:
//   i_clk          - clock, rising edge
//   i_rst          - asynchronous active-high reset
//   i_operand      - signed two's-complement operand, Scale fraction bits
//   i_input_ready  - start request, sampled only while idle
//   o_output_ready - one-cycle completion pulse
//   o_busy         - high from the accepting edge to the completing edge
//   o_result       - unsigned truncated square, held until the next completion
module fixed_point_square_iterative
    import fixed_point_square_iterative_pkg::*;
#(
    parameter int unsigned Width     = WIDTH,
    parameter int unsigned LongWidth = LONG_WIDTH,
    parameter int unsigned Scale     = SCALE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [Width-1:0]     i_operand,
    input  logic                 i_input_ready,
    output logic                 o_output_ready,
    output logic                 o_busy,
    output logic [LongWidth-1:0] o_result
);

    localparam int unsigned CntW = $clog2(Width);

    state_e               r_state;
    logic [Width-1:0]     r_mcand;
    logic [Width-1:0]     r_mplier;
    logic [2*Width-1:0]   r_acc;
    logic [CntW-1:0]      r_count;
    logic [LongWidth-1:0] r_result;
    logic                 r_output_ready;
    logic                 r_busy;

    state_e               w_state_nxt;
    logic [Width-1:0]     w_mcand_nxt;
    logic [Width-1:0]     w_mplier_nxt;
    logic [2*Width-1:0]   w_acc_nxt;
    logic [CntW-1:0]      w_count_nxt;
    logic [LongWidth-1:0] w_result_nxt;
    logic                 w_output_ready_nxt;
    logic                 w_busy_nxt;

    logic [Width-1:0]     w_mag;
    logic [2*Width-1:0]   w_acc_step;

    // Unsigned magnitude; the most negative value maps onto itself, which is
    // exactly its magnitude when read as unsigned.
    assign w_mag = i_operand[Width-1] ? (~i_operand + 1'b1) : i_operand;

    square_shift_add_step #(
        .Width (Width),
        .CntW  (CntW)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier_bit (r_mplier[0]),
        .i_count      (r_count),
        .o_acc        (w_acc_step)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_mcand_nxt        = r_mcand;
        w_mplier_nxt       = r_mplier;
        w_acc_nxt          = r_acc;
        w_count_nxt        = r_count;
        w_result_nxt       = r_result;
        w_output_ready_nxt = 1'b0;
        w_busy_nxt         = r_busy;
        unique case (r_state)
            StIdle: begin
                if (i_input_ready) begin
                    w_mcand_nxt  = w_mag;
                    w_mplier_nxt = w_mag;
                    w_acc_nxt    = '0;
                    w_count_nxt  = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = StIter;
                end
            end
            StIter: begin
                w_acc_nxt    = w_acc_step;
                w_mplier_nxt = r_mplier >> 1;
                w_count_nxt  = r_count + 1'b1;
                // Last step still executes; no early exit keeps latency fixed.
                if (r_count == CntW'(Width - 1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_result_nxt       = LongWidth'(r_acc >> Scale);
                w_output_ready_nxt = 1'b1;
                w_busy_nxt         = 1'b0;
                w_state_nxt        = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_output_ready <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mcand        <= w_mcand_nxt;
            r_mplier       <= w_mplier_nxt;
            r_acc          <= w_acc_nxt;
            r_count        <= w_count_nxt;
            r_result       <= w_result_nxt;
            r_output_ready <= w_output_ready_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign o_output_ready = r_output_ready;
    assign o_busy         = r_busy;
    assign o_result       = r_result;

endmodule

// File: tb/tb_fixed_point_square_iterative.sv
// Bench for fixed_point_square_iterative: directed cases, busy/ignore and
// back-to-back handshakes, asynchronous abort, and randomized operands checked
// against an arithmetic reference (a*a)>>17.
module tb_fixed_point_square_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] operand;
    logic        input_ready;
    logic        output_ready;
    logic        busy;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    fixed_point_square_iterative dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_operand      (operand),
        .i_input_ready  (input_ready),
        .o_output_ready (output_ready),
        .o_busy         (busy),
        .o_result       (result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_sq(input logic [31:0] a);
        longint      sa;
        longint      sq;
        logic [63:0] u;
        sa = longint'($signed(a));
        sq = sa * sa;
        u  = 64'(sq);
        return u >> 17;
    endfunction

    // Called at posedge+1 with the unit idle; returns at E0+1.
    task automatic start_op(input logic [31:0] op);
        operand     = op;
        input_ready = 1'b1;
        @(posedge clk);
        #1;
        input_ready = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (output_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        operand     = '0;
        input_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (output_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_output_ready got=%b want=0", output_ready);
        end
        n_cmp++;
        if (result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result got=%h want=0", result);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] ops  [7] = '{32'h0006_0000, 32'hFFFC_0000, 32'h0003_0000, 32'h0001_0000,
                                  32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
        logic [63:0] exps [7] = '{64'h12_0000, 64'h8_0000, 64'h4_8000, 64'h8000,
                                  64'h0000_2000_0000_0000, 64'h0, 64'h0};
        int lat;
        for (int k = 0; k < 7; k++) begin
            start_op(ops[k]);
            wait_done(lat);
            n_cmp++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL directed_latency op=%h got=%0d want=33", ops[k], lat);
            end
            n_cmp++;
            if (result !== exps[k]) begin
                n_fail++;
                $display("FAIL directed_result op=%h got=%h want=%h", ops[k], result, exps[k]);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_busy_at_pulse got=%b want=0", busy);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (output_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse_width got=%b want=0", output_ready);
            end
        end
    endtask

    task automatic test_busy_ignore_and_back_to_back();
        int pulses;
        int lat;
        start_op(32'h0002_0000);
        repeat (9) @(posedge clk);
        #1;
        // Request while busy: must be dropped, not queued.
        operand     = 32'h0004_0000;
        input_ready = 1'b1;
        pulses      = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            input_ready = 1'b0;
            if (output_ready) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL ignore_pulse_count got=%0d want=1", pulses);
        end
        n_cmp++;
        if (result !== 64'h2_0000) begin
            n_fail++;
            $display("FAIL ignore_result got=%h want=20000", result);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_not_queued_busy got=%b want=0", busy);
        end

        start_op(32'h0004_0000);
        wait_done(lat);
        n_cmp++;
        if (result !== 64'h8_0000) begin
            n_fail++;
            $display("FAIL b2b_first_result got=%h want=80000", result);
        end
        // Request in the pulse cycle is accepted at the next edge.
        operand     = 32'h0006_0000;
        input_ready = 1'b1;
        lat         = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            input_ready = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_accept_busy got=%b want=1", busy);
                end
            end
            if (output_ready) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL b2b_latency got=%0d want=34", lat);
        end
        n_cmp++;
        if (result !== 64'h12_0000) begin
            n_fail++;
            $display("FAIL b2b_second_result got=%h want=120000", result);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        start_op(32'h0006_0000);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (result !== 64'd0) begin
            n_fail++;
            $display("FAIL abort_result got=%h want=0", result);
        end
        #4;
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (output_ready || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_pulse got=%0d want=0", pulses);
        end
        start_op(32'h0006_0000);
        wait_done(lat);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL abort_recover_latency got=%0d want=33", lat);
        end
        n_cmp++;
        if (result !== 64'h12_0000) begin
            n_fail++;
            $display("FAIL abort_recover_result got=%h want=120000", result);
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_FFFF};
        logic [31:0] op;
        logic [63:0] prev;
        logic [63:0] want;
        int          lat;
        for (int k = 0; k < 300; k++) begin
            op   = (k % 25 == 0) ? corners[(k / 25) % 4] : $urandom;
            want = ref_sq(op);
            prev = result;
            start_op(op);
            // Operand changes after acceptance must not matter.
            operand = $urandom;
            lat     = -1;
            for (int i = 1; i <= 60; i++) begin
                @(posedge clk);
                #1;
                if (output_ready) begin
                    lat = i;
                    break;
                end
                n_cmp++;
                if (result !== prev) begin
                    n_fail++;
                    $display("FAIL rand_result_stable op=%h got=%h want=%h", op, result, prev);
                end
            end
            n_cmp++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL rand_latency op=%h got=%0d want=33", op, lat);
            end
            n_cmp++;
            if (result !== want) begin
                n_fail++;
                $display("FAIL rand_result op=%h got=%h want=%h", op, result, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore_and_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
